uart_rx_sampler: RTL and testbench

Oversampling UART receive front end. It turns the raw asynchronous `rx` pin into validated bytes plus a one-cycle strobe that writes the byte FIFO. It replaces the simple baud-clocked receive path with a single-clock design: a 16x tick enable, majority-vote sampling, false-start rejection and framing-error detection. It sits between the `rx` pin and the FIFO write port (`wr`/`data_in`).

---
 rtl/uart_pkg.sv | 24 ++
 rtl/uart_baud_tick.sv | 29 ++
 rtl/uart_rx_sampler.sv | 169 ++++++++++++++++
 tb/tb_uart_rx_sampler.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared FSM states, oversampling constants and vote helper for the UART path
// Contents:
//   state_t     receive FSM states (PARITY only reachable when UART_RX_PARITY_EN is defined)
//   OVERSAMPLE  ticks per bit; SW is the width of the sample index
//   SMP_A..C    sample indices used by the 3-sample majority vote
//   DEC_IDX     sample index on which a bit value is decided
//   maj3        2-of-3 majority
package uart_pkg;

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} state_t;

    localparam int OVERSAMPLE = 16;
    localparam int SW = $clog2(OVERSAMPLE);

    localparam logic [SW-1:0] SMP_A   = SW'(7);
    localparam logic [SW-1:0] SMP_B   = SW'(8);
    localparam logic [SW-1:0] SMP_C   = SW'(9);
    localparam logic [SW-1:0] DEC_IDX = SMP_C;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: CLK_DIV divider producing a one-cycle oversample tick
// Ports:
//   i_clk      system clock
//   i_reset    asynchronous active-high reset
//   i_restart  synchronous; forces the count to 0 so ticks re-align to this cycle
//   o_tick     high for one cycle when the count reaches CLK_DIV-1
module uart_baud_tick #(
    parameter int CLK_DIV = 326
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_restart,
    output logic o_tick
);

    localparam int CW = $clog2(CLK_DIV);

    logic [CW-1:0] r_cnt;

    assign o_tick = r_cnt == CW'(CLK_DIV - 1);

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset)
            r_cnt <= '0;
        else
            r_cnt <= (i_restart || o_tick) ? '0 : r_cnt + 1'b1;
    end

endmodule

// File: rtl/uart_rx_sampler.sv
// uart_rx_sampler: 16x oversampling UART receiver with majority vote, false-start and framing checks
// Ports:
//   i_clk        system clock
//   i_reset      asynchronous active-high reset
//   i_rx         raw serial input, idle high, asynchronous to i_clk
//   o_data_out   last good byte, updated together with o_rxDone
//   o_rxDone     one-cycle strobe for a good frame (FIFO write)
//   o_frameErr   one-cycle strobe when the stop bit votes low
//   o_busy       high while the FSM is not IDLE
//   o_parityErr  one-cycle strobe on even-parity mismatch (only with UART_RX_PARITY_EN)
// Build option: define UART_RX_PARITY_EN for frames carrying one even-parity bit.
module uart_rx_sampler
    import uart_pkg::*;
#(
    parameter int DATA_BITS = 8,
    parameter int CLK_DIV   = 326
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_rx,
    output logic [DATA_BITS-1:0] o_data_out,
    output logic                 o_rxDone,
    output logic                 o_frameErr,
    output logic                 o_busy
`ifdef UART_RX_PARITY_EN
    ,
    output logic                 o_parityErr
`endif
);

    localparam int BW = $clog2(DATA_BITS + 3);

    state_t               r_state;
    state_t               w_next;
    logic [1:0]           r_sync;
    logic [SW-1:0]        r_s;
    logic [BW-1:0]        r_bit;
    logic [1:0]           r_smp;
    logic [DATA_BITS-1:0] r_shift;
    logic [DATA_BITS-1:0] r_data;
    logic                 r_done;
    logic                 r_ferr;
    logic                 w_rxs;
    logic                 w_tick;
    logic                 w_start;
    logic                 w_dec;
    logic                 w_vote;
    logic                 w_done;
    logic                 w_ferr;
`ifdef UART_RX_PARITY_EN
    logic                 r_par;
    logic                 r_perr;
    logic                 w_perr;
`endif

    assign w_rxs   = r_sync[1];
    assign w_start = (r_state == IDLE) && !w_rxs;
    assign w_dec   = w_tick && (r_s == DEC_IDX);
    assign w_vote  = maj3(r_smp[0], r_smp[1], w_rxs);

    uart_baud_tick #(
        .CLK_DIV(CLK_DIV)
    ) u_tick (
        .i_clk    (i_clk),
        .i_reset  (i_reset),
        .i_restart(w_start),
        .o_tick   (w_tick)
    );

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    // r_bit holds the index of the bit period in progress (0 = start bit)
    always_comb begin
        w_next = r_state;
        w_done = 1'b0;
        w_ferr = 1'b0;
`ifdef UART_RX_PARITY_EN
        w_perr = 1'b0;
`endif
        case (r_state)
            IDLE:  if (!w_rxs) w_next = START;
            START: if (w_dec) w_next = w_vote ? IDLE : DATA;
            DATA:  if (w_dec && r_bit == BW'(DATA_BITS))
`ifdef UART_RX_PARITY_EN
                       w_next = PARITY;
            PARITY: if (w_dec) w_next = STOP;
`else
                       w_next = STOP;
`endif
            STOP: begin
                if (w_dec) begin
                    if (!w_vote) begin
                        w_ferr = 1'b1;
                        w_next = BREAK;
                    end else begin
                        w_next = IDLE;
`ifdef UART_RX_PARITY_EN
                        w_perr = ^{r_shift, r_par};
                        w_done = !w_perr;
`else
                        w_done = 1'b1;
`endif
                    end
                end
            end
            BREAK: if (w_rxs) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_sync  <= 2'b11;
            r_s     <= '0;
            r_bit   <= '0;
            r_smp   <= '0;
            r_shift <= '0;
            r_data  <= '0;
            r_done  <= 1'b0;
            r_ferr  <= 1'b0;
        end else begin
            r_sync <= {r_sync[0], i_rx};
            r_done <= w_done;
            r_ferr <= w_ferr;
            if (w_start) begin
                r_s   <= '0;
                r_bit <= '0;
            end else if (w_tick) begin
                r_s <= r_s + 1'b1;
                if (r_s == SW'(OVERSAMPLE - 1))
                    r_bit <= r_bit + 1'b1;
            end
            if (w_tick && r_s == SMP_A)
                r_smp[0] <= w_rxs;
            if (w_tick && r_s == SMP_B)
                r_smp[1] <= w_rxs;
            if (w_dec && r_state == DATA)
                r_shift <= {w_vote, r_shift[DATA_BITS-1:1]};
            if (w_done)
                r_data <= r_shift;
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_par  <= 1'b0;
            r_perr <= 1'b0;
        end else begin
            r_perr <= w_perr;
            if (w_dec && r_state == PARITY)
                r_par <= w_vote;
        end
    end

    assign o_parityErr = r_perr;
`endif

    assign o_data_out = r_data;
    assign o_rxDone   = r_done;
    assign o_frameErr = r_ferr;
    assign o_busy     = r_state != IDLE;

endmodule

// File: tb/tb_uart_rx_sampler.sv
// tb_uart_rx_sampler: table, hand-written and random frames checked against a frame-level model
module tb_uart_rx_sampler;

    localparam int CLK_DIV = 4;
    localparam int BIT     = 16 * CLK_DIV;
`ifdef UART_RX_PARITY_EN
    localparam int PAR_EN  = 1;
`else
    localparam int PAR_EN  = 0;
`endif
    localparam int NB      = 8 + PAR_EN;
    localparam int LAT     = 3 + (16 * (NB + 1) + 10) * CLK_DIV;
    localparam int K_DONE  = 0;
    localparam int K_FERR  = 1;
    localparam int K_PERR  = 2;

    typedef struct {
        logic [7:0] d;
        logic       stop;
        int         hold;
        int         gap;
        int         kind;
        logic [7:0] dout;
    } vec_t;

    typedef struct {
        int         kind;
        logic [7:0] d;
        int         cyc;
    } ev_t;

    logic       clk = 1'b0;
    logic       i_reset = 1'b1;
    logic       i_rx = 1'b1;
    logic [7:0] o_data_out;
    logic       o_rxDone;
    logic       o_frameErr;
    logic       o_busy;
    logic       perr;
    int         cyc = 0;
    int         n_tests = 0;
    int         n_fail = 0;
    ev_t        evq[$];
    vec_t       tbl[7];
    logic [7:0] exp_dout;
    logic       prev_p = 1'b0;
    logic [7:0] prev_dout = 8'h00;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_rx_sampler #(
        .DATA_BITS(8),
        .CLK_DIV  (CLK_DIV)
    ) dut (
        .i_clk      (clk),
        .i_reset    (i_reset),
        .i_rx       (i_rx),
        .o_data_out (o_data_out),
        .o_rxDone   (o_rxDone),
        .o_frameErr (o_frameErr),
        .o_busy     (o_busy)
`ifdef UART_RX_PARITY_EN
        ,
        .o_parityErr(perr)
`endif
    );
`ifndef UART_RX_PARITY_EN
    assign perr = 1'b0;
`endif

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Records status pulses; also checks 1-cycle width, exclusivity and data_out stability
    always @(negedge clk) begin
        if (i_reset) begin
            prev_p = 1'b0;
            prev_dout = o_data_out;
        end else begin
            if (o_rxDone || o_frameErr || perr) begin
                n_tests++;
                if (prev_p || (int'(o_rxDone) + int'(o_frameErr) + int'(perr)) != 1) begin
                    n_fail++;
                    $display("FAIL pulse_shape: done=%0b ferr=%0b perr=%0b prev=%0b, required single 1-cycle pulse",
                             o_rxDone, o_frameErr, perr, prev_p);
                end
                evq.push_back('{o_rxDone ? K_DONE : (o_frameErr ? K_FERR : K_PERR), o_data_out, cyc});
            end
            if (o_data_out !== prev_dout) begin
                n_tests++;
                if (!o_rxDone) begin
                    n_fail++;
                    $display("FAIL dout_change: data_out %0h->%0h with rxDone=0, required rxDone=1",
                             prev_dout, o_data_out);
                end
            end
            prev_p = o_rxDone || o_frameErr || perr;
            prev_dout = o_data_out;
        end
    end

    task automatic drive(input logic v, input int n);
        i_rx = v;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic int model_kind(input logic [7:0] d, input logic par, input logic stop);
        if (!stop) return K_FERR;
        if (PAR_EN != 0 && ((^d) != par)) return K_PERR;
        return K_DONE;
    endfunction

    task automatic run_frame(input logic [7:0] d, input logic par, input logic stop, input int hold,
                             input int gap, input int kind, input logic [7:0] dout);
        ev_t e;
        int  start;
        start = cyc;
        drive(1'b0, BIT);
        for (int i = 0; i < 8; i++) drive(d[i], BIT);
        if (PAR_EN != 0) drive(par, BIT);
        drive(stop, BIT + (stop ? 0 : hold));
        check("event_count", evq.size(), 1);
        if (evq.size() > 0) begin
            e = evq.pop_front();
            check("event_kind", e.kind, kind);
            check("latency", e.cyc - start, LAT);
            if (kind == K_DONE) check("event_data", e.d, dout);
        end
        evq.delete();
        check("data_out", o_data_out, dout);
        drive(1'b1, gap);
    endtask

    initial begin
        int         start;
        logic [7:0] d;
        logic [7:0] v;
        logic       stop;
        logic       par;
        int         hold;
        int         gap;
        int         kind;

        tbl[0] = '{8'hA5, 1'b1, 0,   100, K_DONE, 8'hA5};
        tbl[1] = '{8'h3C, 1'b0, 500, 100, K_FERR, 8'hA5};
        tbl[2] = '{8'h11, 1'b1, 0,   100, K_DONE, 8'h11};
        tbl[3] = '{8'h00, 1'b1, 0,   0,   K_DONE, 8'h00};
        tbl[4] = '{8'hFF, 1'b1, 0,   100, K_DONE, 8'hFF};
        tbl[5] = '{8'h80, 1'b1, 0,   0,   K_DONE, 8'h80};
        tbl[6] = '{8'h01, 1'b0, 0,   64,  K_FERR, 8'h80};

        repeat (3) @(posedge clk);
        #1;
        check("rst_data_out", o_data_out, 0);
        check("rst_rxDone", o_rxDone, 0);
        check("rst_frameErr", o_frameErr, 0);
        check("rst_busy", o_busy, 0);
        check("rst_parityErr", perr, 0);
        i_reset = 1'b0;
        drive(1'b1, 20);

        for (int i = 0; i < 7; i++)
            run_frame(tbl[i].d, ^tbl[i].d, tbl[i].stop, tbl[i].hold, tbl[i].gap, tbl[i].kind, tbl[i].dout);
        exp_dout = 8'h80;
        check("busy_idle", o_busy, 0);

        start = cyc;
        drive(1'b0, 12);
        drive(1'b1, 8);
        check("glitch_busy_high", o_busy, 1);
        drive(1'b1, 50 - (cyc - start));
        check("glitch_busy_low", o_busy, 0);
        check("glitch_no_event", evq.size(), 0);
        check("glitch_data_out", o_data_out, exp_dout);
        drive(1'b1, 40);

        v = 8'h5A;
        drive(1'b0, BIT);
        for (int i = 0; i < 4; i++) drive(v[i], BIT);
        drive(v[4], BIT / 2);
        i_reset = 1'b1;
        #1;
        check("mid_rst_data_out", o_data_out, 0);
        check("mid_rst_busy", o_busy, 0);
        check("mid_rst_pulses", {o_rxDone, o_frameErr, perr}, 0);
        repeat (5) @(posedge clk);
        #1;
        i_rx = 1'b1;
        i_reset = 1'b0;
        drive(1'b1, 100);
        check("post_rst_no_event", evq.size(), 0);
        check("post_rst_busy", o_busy, 0);
        exp_dout = 8'h00;
        run_frame(8'hC3, ^v[7:0] ^ ^v[7:0] ^ 1'b0, 1'b1, 0, 100, K_DONE, 8'hC3);
        exp_dout = 8'hC3;

`ifdef UART_RX_PARITY_EN
        run_frame(8'h07, 1'b0, 1'b1, 0, 100, K_PERR, exp_dout);
        run_frame(8'h07, 1'b1, 1'b1, 0, 100, K_DONE, 8'h07);
        exp_dout = 8'h07;
`endif

        for (int n = 0; n < 24; n++) begin
            d    = 8'($urandom);
            stop = $urandom_range(0, 4) != 0;
            par  = (^d) ^ ((PAR_EN != 0) && ($urandom_range(0, 3) == 0));
            hold = stop ? 0 : int'($urandom_range(0, 200));
            gap  = !stop ? int'($urandom_range(64, 150)) :
                   ($urandom_range(0, 2) == 0 ? 0 : int'($urandom_range(1, 80)));
            kind = model_kind(d, par, stop);
            if (kind == K_DONE) exp_dout = d;
            run_frame(d, par, stop, hold, gap, kind, exp_dout);
        end
        drive(1'b1, 100);
        check("final_busy", o_busy, 0);
        check("final_no_event", evq.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
